// File: rtl/dout_window_accum.sv
// Window accumulator for the dout_data/dout_valid stream: each window of WINDOW
// valid samples yields {sum, max, min}, delivered through a 2-entry valid/ready FIFO.
module dout_window_accum #(
    parameter  int DWIDTH = 16,
    parameter  int WINDOW = 4,
    localparam int SWIDTH = DWIDTH + $clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] din_data,
    input  logic              din_valid,
    output logic [SWIDTH-1:0] dout_sum,
    output logic [DWIDTH-1:0] dout_max,
    output logic [DWIDTH-1:0] dout_min,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overflow
);

    localparam int CW = $clog2(WINDOW);
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

    // window accumulation state
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] max_q, max_d;
    logic [DWIDTH-1:0] min_q, min_d;

    // output fifo state
    logic [SWIDTH-1:0] sum_mem_q [0:1];
    logic [SWIDTH-1:0] sum_mem_d [0:1];
    logic [DWIDTH-1:0] max_mem_q [0:1];
    logic [DWIDTH-1:0] max_mem_d [0:1];
    logic [DWIDTH-1:0] min_mem_q [0:1];
    logic [DWIDTH-1:0] min_mem_d [0:1];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              win_done;
    logic              fifo_full;
    logic              fifo_pop;
    logic              fifo_push;
    logic              fifo_drop;
    logic [SWIDTH-1:0] sample_ext;

    always_comb begin
        sample_ext = SWIDTH'(din_data);
        win_done   = din_valid && (cnt_q == CNT_LAST);
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        max_d      = max_q;
        min_d      = min_q;
        if (din_valid) begin
            if (cnt_q == '0) begin
                acc_d = sample_ext;
                max_d = din_data;
                min_d = din_data;
            end else begin
                acc_d = acc_q + sample_ext;
                if (din_data > max_q) max_d = din_data;
                if (din_data < min_q) min_d = din_data;
            end
            cnt_d = win_done ? '0 : cnt_q + CW'(1);
        end
    end

    // A full fifo still accepts a result when the head leaves on the same edge.
    always_comb begin
        fifo_full  = (count_q == 2'd2);
        fifo_pop   = (count_q != 2'd0) && dout_ready;
        fifo_push  = win_done && (!fifo_full || fifo_pop);
        fifo_drop  = win_done && fifo_full && !fifo_pop;

        sum_mem_d  = sum_mem_q;
        max_mem_d  = max_mem_q;
        min_mem_d  = min_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | fifo_drop;

        if (fifo_push) begin
            sum_mem_d[wr_ptr_q] = acc_d;
            max_mem_d[wr_ptr_q] = max_d;
            min_mem_d[wr_ptr_q] = min_d;
            wr_ptr_d            = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                sum_mem_q[i] <= '0;
                max_mem_q[i] <= '0;
                min_mem_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
            min_q      <= min_d;
            sum_mem_q  <= sum_mem_d;
            max_mem_q  <= max_mem_d;
            min_mem_q  <= min_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign dout_sum   = sum_mem_q[rd_ptr_q];
    assign dout_max   = max_mem_q[rd_ptr_q];
    assign dout_min   = min_mem_q[rd_ptr_q];
    assign dout_valid = (count_q != 2'd0);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dout_window_accum.sv
// Directed bench for dout_window_accum (DWIDTH=16, WINDOW=4) with hand-computed results.
module tb_dout_window_accum;

    logic        clk;
    logic        rst;
    logic [15:0] din_data;
    logic        din_valid;
    logic [17:0] dout_sum;
    logic [15:0] dout_max;
    logic [15:0] dout_min;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    dout_window_accum #(.DWIDTH(16), .WINDOW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .dout_sum   (dout_sum),
        .dout_max   (dout_max),
        .dout_min   (dout_min),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        din_data  = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic gap();
        din_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; din_data = '0; din_valid = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        chk("reset_valid", 32'(dout_valid), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_sum", 32'(dout_sum), 32'd0);
        rst = 1'b0;

        // 1: back-to-back window, ready high
        dout_ready = 1'b1;
        send(16'd1); send(16'd2); send(16'd3);
        chk("t1_mid_valid", 32'(dout_valid), 32'd0);
        send(16'd4);
        chk("t1_valid", 32'(dout_valid), 32'd1);
        chk("t1_sum", 32'(dout_sum), 32'd10);
        chk("t1_max", 32'(dout_max), 32'd4);
        chk("t1_min", 32'(dout_min), 32'd1);
        gap();
        chk("t1_one_cycle", 32'(dout_valid), 32'd0);

        // 2: gaps between samples
        send(16'd9); gap(); send(16'd7); gap(); gap(); send(16'd3);
        chk("t2_mid_valid", 32'(dout_valid), 32'd0);
        send(16'd5);
        chk("t2_valid", 32'(dout_valid), 32'd1);
        chk("t2_sum", 32'(dout_sum), 32'd24);
        chk("t2_max", 32'(dout_max), 32'd9);
        chk("t2_min", 32'(dout_min), 32'd3);
        gap();
        chk("t2_popped", 32'(dout_valid), 32'd0);

        // 3: stalled consumer, third window dropped
        dout_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(16'(i));
        chk("t3_two_held_ovf", 32'(overflow), 32'd0);
        chk("t3_two_held_sum", 32'(dout_sum), 32'd10);
        for (int i = 9; i <= 12; i++) send(16'(i));
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head_stable", 32'(dout_sum), 32'd10);
        gap(); gap();
        chk("t3_stall_valid", 32'(dout_valid), 32'd1);
        chk("t3_stall_sum", 32'(dout_sum), 32'd10);
        dout_ready = 1'b1;
        gap();
        chk("t3_second_valid", 32'(dout_valid), 32'd1);
        chk("t3_second_sum", 32'(dout_sum), 32'd26);
        chk("t3_second_max", 32'(dout_max), 32'd8);
        chk("t3_second_min", 32'(dout_min), 32'd5);
        gap();
        chk("t3_empty", 32'(dout_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: push and pop while full
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd1);
        for (int i = 0; i < 4; i++) send(16'd2);
        send(16'd3); send(16'd3); send(16'd3);
        dout_ready = 1'b1;
        send(16'd3);
        chk("t4_no_drop_ovf", 32'(overflow), 32'd0);
        chk("t4_head_valid", 32'(dout_valid), 32'd1);
        chk("t4_head_sum", 32'(dout_sum), 32'd8);
        gap();
        chk("t4_tail_valid", 32'(dout_valid), 32'd1);
        chk("t4_tail_sum", 32'(dout_sum), 32'd12);
        chk("t4_tail_max", 32'(dout_max), 32'd3);
        gap();
        chk("t4_empty", 32'(dout_valid), 32'd0);
        chk("t4_ovf_final", 32'(overflow), 32'd0);

        // 1-entry push+pop: new result becomes head next cycle
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd6);
        send(16'd7); send(16'd7); send(16'd7);
        dout_ready = 1'b1;
        send(16'd7);
        chk("t4b_valid", 32'(dout_valid), 32'd1);
        chk("t4b_sum", 32'(dout_sum), 32'd28);
        gap();
        chk("t4b_empty", 32'(dout_valid), 32'd0);

        // 5: full-scale samples, sum must not wrap
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        chk("t5_sum", 32'(dout_sum), 32'h3FFFC);
        chk("t5_max", 32'(dout_max), 32'hFFFF);
        chk("t5_min", 32'(dout_min), 32'hFFFF);
        gap();

        // 6: partial window discarded by reset
        send(16'd7); send(16'd8);
        rst = 1'b1; tick();
        chk("t6_during_rst", 32'(dout_valid), 32'd0);
        rst = 1'b0;
        send(16'd4);
        chk("t6_after1", 32'(dout_valid), 32'd0);
        send(16'd4);
        chk("t6_after2", 32'(dout_valid), 32'd0);
        send(16'd4);
        chk("t6_after3", 32'(dout_valid), 32'd0);
        send(16'd4);
        chk("t6_valid", 32'(dout_valid), 32'd1);
        chk("t6_sum", 32'(dout_sum), 32'd16);
        chk("t6_max", 32'(dout_max), 32'd4);
        chk("t6_min", 32'(dout_min), 32'd4);
        gap();
        chk("t6_only_one", 32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
